// File: rtl/adc_ms_result_avg.sv
// Multislope ADC result post-processor: converts each 48-bit result word to a signed
// charge-balance value, averages blocks of 2^avg_log2 samples and presents the mean on a valid/ready register.
module adc_ms_result_avg #(
    parameter int unsigned RUNUP_WEIGHT = 3200
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic        res_valid,
    input  logic [47:0] res_data,
    input  logic [3:0]  avg_log2,
    input  logic        acc_clr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_range_err,
    output logic        out_overrun
);

    localparam logic signed [31:0] LP_WEIGHT = 32'(RUNUP_WEIGHT);

    logic [14:0] w_runup_cnt;
    logic [14:0] w_runup_set;
    logic        w_rd_sign;
    logic [15:0] w_rd_cnt;
    assign w_runup_cnt = res_data[46:32];
    assign w_rd_sign   = res_data[31];
    assign w_runup_set = res_data[30:16];
    assign w_rd_cnt    = res_data[15:0];

    logic signed [16:0] w_runup_term;
    logic signed [16:0] w_rd_signed;
    logic               w_sample_err;
    assign w_runup_term = $signed({1'b0, w_runup_cnt, 1'b0}) - $signed({2'b00, w_runup_set}) - 17'sd1;
    assign w_rd_signed  = w_rd_sign ? -$signed({1'b0, w_rd_cnt}) : $signed({1'b0, w_rd_cnt});
    assign w_sample_err = (w_runup_cnt > w_runup_set) || (w_rd_cnt == 16'hFFFF);

    logic               r_s1_valid;
    logic signed [16:0] r_s1_runup;
    logic signed [16:0] r_s1_rd;
    logic               r_s1_err;
    logic               r_s2_valid;
    logic signed [31:0] r_s2_v;
    logic               r_s2_err;

    logic signed [31:0] w_v;
    assign w_v = LP_WEIGHT * $signed({{15{r_s1_runup[16]}}, r_s1_runup})
               + $signed({{15{r_s1_rd[16]}}, r_s1_rd});

    // acc_clr drops both the incoming strobe and whatever is already in S1/S2.
    always_ff @(posedge mclk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_runup <= '0;
            r_s1_rd    <= '0;
            r_s1_err   <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_v     <= '0;
            r_s2_err   <= 1'b0;
        end else begin
            r_s1_valid <= res_valid && !acc_clr;
            r_s1_runup <= w_runup_term;
            r_s1_rd    <= w_rd_signed;
            r_s1_err   <= w_sample_err;
            r_s2_valid <= r_s1_valid && !acc_clr;
            r_s2_v     <= w_v;
            r_s2_err   <= r_s1_err;
        end
    end

    logic signed [39:0] r_acc;
    logic [8:0]         r_cnt;
    logic               r_err;
    logic [3:0]         r_log2;

    logic signed [39:0] w_acc_next;
    logic [8:0]         w_cnt_next;
    logic               w_err_next;
    logic [3:0]         w_log2_next;

    logic [3:0]         w_log2_sel;
    logic [3:0]         w_log2_eff;
    logic signed [39:0] w_acc_sum;
    logic [8:0]         w_cnt_inc;
    logic               w_err_sum;
    logic               w_block_done;
    logic signed [39:0] w_mean_full;

    // The block size is frozen when the first sample of a block reaches S3.
    assign w_log2_sel   = (avg_log2 > 4'd8) ? 4'd8 : avg_log2;
    assign w_log2_eff   = (r_cnt == 9'd0) ? w_log2_sel : r_log2;
    assign w_acc_sum    = r_acc + $signed({{8{r_s2_v[31]}}, r_s2_v});
    assign w_cnt_inc    = r_cnt + 9'd1;
    assign w_err_sum    = r_err | r_s2_err;
    assign w_block_done = r_s2_valid && !acc_clr && (w_cnt_inc == (9'd1 << w_log2_eff));
    assign w_mean_full  = w_acc_sum >>> w_log2_eff;

    logic w_unused;
    assign w_unused = ^{res_data[47], w_mean_full[39:32]};

    always_ff @(posedge mclk) begin
        if (rst) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
            r_log2 <= '0;
        end else begin
            r_acc  <= w_acc_next;
            r_cnt  <= w_cnt_next;
            r_err  <= w_err_next;
            r_log2 <= w_log2_next;
        end
    end

    // Single-state block control: the boundary is purely count-driven.
    always_comb begin
        w_acc_next  = r_acc;
        w_cnt_next  = r_cnt;
        w_err_next  = r_err;
        w_log2_next = r_log2;
        if (acc_clr) begin
            w_acc_next = '0;
            w_cnt_next = '0;
            w_err_next = 1'b0;
        end else if (r_s2_valid) begin
            w_log2_next = w_log2_eff;
            if (w_block_done) begin
                w_acc_next = '0;
                w_cnt_next = '0;
                w_err_next = 1'b0;
            end else begin
                w_acc_next = w_acc_sum;
                w_cnt_next = w_cnt_inc;
                w_err_next = w_err_sum;
            end
        end
    end

    logic        w_xfer;
    logic        w_out_valid_next;
    logic [31:0] w_out_data_next;
    logic        w_out_err_next;
    logic        w_overrun_next;

    always_comb begin
        w_xfer           = out_valid && out_ready;
        w_out_valid_next = w_block_done || (out_valid && !w_xfer);
        w_out_data_next  = w_block_done ? w_mean_full[31:0] : out_data;
        w_out_err_next   = w_block_done ? w_err_sum : out_range_err;
        w_overrun_next   = out_overrun || (w_block_done && out_valid && !w_xfer);
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_range_err <= 1'b0;
            out_overrun   <= 1'b0;
        end else begin
            out_valid     <= w_out_valid_next;
            out_data      <= w_out_data_next;
            out_range_err <= w_out_err_next;
            out_overrun   <= w_overrun_next;
        end
    end

endmodule

// File: tb/tb_adc_ms_result_avg.sv
// Scoreboard bench for adc_ms_result_avg: a behavioural model queues expected means as
// samples are driven; a monitor pops and compares them whenever a mean is accepted.
module tb_adc_ms_result_avg;

    localparam int RW = 3200;

    logic        mclk = 1'b0;
    logic        rst;
    logic        res_valid;
    logic [47:0] res_data;
    logic [3:0]  avg_log2;
    logic        acc_clr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_range_err;
    logic        out_overrun;

    always #5 mclk = ~mclk;

    adc_ms_result_avg #(.RUNUP_WEIGHT(RW)) dut (
        .mclk(mclk), .rst(rst), .res_valid(res_valid), .res_data(res_data),
        .avg_log2(avg_log2), .acc_clr(acc_clr), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_range_err(out_range_err),
        .out_overrun(out_overrun)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t   exp_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    int     n_xfer  = 0;
    longint m_sum   = 0;
    int     m_cnt   = 0;
    int     m_log2  = 0;
    bit     m_err   = 0;

    function automatic longint model_v(input int cnt, input int set, input bit sign, input int rd);
        return longint'(RW) * longint'(2 * cnt - set - 1) + (sign ? -longint'(rd) : longint'(rd));
    endfunction

    function automatic logic [47:0] word(input int cnt, input int set, input bit sign, input int rd);
        return {1'b1, 15'(cnt), sign, 15'(set), 16'(rd)};
    endfunction

    task automatic model_reset();
        m_sum = 0; m_cnt = 0; m_err = 0;
    endtask

    task automatic model_push(input int cnt, input int set, input bit sign, input int rd);
        exp_t e;
        if (m_cnt == 0) m_log2 = (avg_log2 > 4'd8) ? 8 : int'(avg_log2);
        m_sum += model_v(cnt, set, sign, rd);
        m_err |= (cnt > set) || (rd == 65535);
        m_cnt++;
        if (m_cnt == (1 << m_log2)) begin
            e.data = 32'(m_sum >>> m_log2);
            e.err  = m_err;
            exp_q.push_back(e);
            model_reset();
        end
    endtask

    task automatic send(input int cnt, input int set, input bit sign, input int rd);
        model_push(cnt, set, sign, rd);
        @(posedge mclk); #1;
        res_valid = 1'b1;
        res_data  = word(cnt, set, sign, rd);
        @(posedge mclk); #1;
        res_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge mclk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d means still pending, required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    always @(negedge mclk) begin : monitor
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            n_xfer++;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_mean: got data %0d err %0b, required no output",
                         $signed(out_data), out_range_err);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e.data || out_range_err !== e.err) begin
                    n_fail++;
                    $display("FAIL mean: got data %0d err %0b, required data %0d err %0b",
                             $signed(out_data), out_range_err, $signed(e.data), e.err);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; res_valid = 1'b0; res_data = '0; avg_log2 = '0; acc_clr = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge mclk);
        #1;
        n_tests++;
        if ({out_valid, out_data, out_range_err, out_overrun} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b/%h/%b/%b, required 0/00000000/0/0",
                     out_valid, out_data, out_range_err, out_overrun);
        end
        rst = 1'b0;
        $display("[TB] reset checked");
    endtask

    task automatic test_scalar();
        avg_log2 = 4'd0;
        send(1000, 1999, 0, 500);
        @(posedge mclk); #1;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: got out_valid %b after S2, required 0", out_valid);
        end
        @(posedge mclk); #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 32'd500) begin
            n_fail++;
            $display("FAIL latency_load: got valid %b data %0d, required valid 1 data 500",
                     out_valid, $signed(out_data));
        end
        send(1100, 1999, 1, 300);
        wait_drain(20);
        $display("[TB] scalar: two single-sample means");
    endtask

    task automatic test_average();
        int x0;
        avg_log2 = 4'd2;
        x0 = n_xfer;
        send(1000, 1999, 0, 100);
        send(1000, 1999, 0, 200);
        send(1000, 1999, 0, 300);
        send(1000, 1999, 1, 200);
        wait_drain(20);
        repeat (4) @(posedge mclk);
        n_tests++;
        if (n_xfer - x0 !== 1) begin
            n_fail++;
            $display("FAIL avg4_count: got %0d means, required 1", n_xfer - x0);
        end
        $display("[TB] average of 4 samples");
    endtask

    task automatic test_floor_and_clamp();
        int x0;
        avg_log2 = 4'd1;
        send(1000, 1999, 1, 2);
        send(1000, 1999, 1, 3);
        wait_drain(20);
        avg_log2 = 4'd12;
        x0 = n_xfer;
        for (int i = 0; i < 255; i++)
            send($urandom_range(900, 1100), 1999, 1'($urandom_range(0, 1)), $urandom_range(0, 60000));
        repeat (6) @(posedge mclk);
        n_tests++;
        if (n_xfer !== x0) begin
            n_fail++;
            $display("FAIL clamp_early: got %0d means after 255 samples, required 0", n_xfer - x0);
        end
        send(1000, 1999, 0, 7);
        wait_drain(20);
        n_tests++;
        if (n_xfer - x0 !== 1) begin
            n_fail++;
            $display("FAIL clamp_count: got %0d means after 256 samples, required 1", n_xfer - x0);
        end
        $display("[TB] floor rounding and avg_log2 clamp");
    endtask

    task automatic test_range();
        avg_log2 = 4'd1;
        send(2000, 1999, 0, 10);
        send(1000, 1999, 0, 20);
        wait_drain(20);
        send(1000, 1999, 0, 30);
        send(999, 1999, 1, 40);
        wait_drain(20);
        send(1000, 1999, 0, 65535);
        send(1000, 1999, 0, 1);
        wait_drain(20);
        $display("[TB] range error flag");
    endtask

    task automatic test_acc_clr();
        int x0;
        avg_log2 = 4'd1;
        send(1000, 1999, 0, 50);
        repeat (4) @(posedge mclk);
        #1;
        acc_clr = 1'b1; res_valid = 1'b1; res_data = word(1000, 1999, 0, 9999);
        @(posedge mclk); #1;
        acc_clr = 1'b0; res_valid = 1'b0;
        model_reset();
        x0 = n_xfer;
        send(1001, 1999, 0, 60);
        repeat (6) @(posedge mclk);
        n_tests++;
        if (n_xfer !== x0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_partial: got %0d means valid %b, required 0 means valid 0", n_xfer - x0, out_valid);
        end
        send(999, 1999, 1, 70);
        wait_drain(20);
        n_tests++;
        if (n_xfer - x0 !== 1) begin
            n_fail++;
            $display("FAIL clr_count: got %0d means, required 1", n_xfer - x0);
        end
        $display("[TB] acc_clr with coincident strobe");
    endtask

    task automatic test_coincide();
        avg_log2 = 4'd0;
        out_ready = 1'b0;
        send(1000, 1999, 0, 11);
        repeat (3) @(posedge mclk);
        send(1000, 1999, 0, 22);
        @(posedge mclk); #1;
        out_ready = 1'b1;
        @(posedge mclk); #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 32'd22 || out_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL coincide: got valid %b data %0d overrun %b, required 1 22 0",
                     out_valid, $signed(out_data), out_overrun);
        end
        wait_drain(20);
        $display("[TB] transfer coinciding with load");
    endtask

    task automatic test_backpressure();
        logic [31:0] y;
        avg_log2 = 4'd0;
        out_ready = 1'b0;
        y = 32'(model_v(1050, 1999, 1, 123));
        send(1020, 1999, 0, 77);
        send(1050, 1999, 1, 123);
        repeat (4) @(posedge mclk);
        #1;
        exp_q.delete(0);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== y || out_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overwrite: got valid %b data %0d overrun %b, required 1 %0d 1",
                     out_valid, $signed(out_data), out_overrun, $signed(y));
        end
        out_ready = 1'b1;
        wait_drain(20);
        repeat (2) @(posedge mclk);
        #1;
        n_tests++;
        if (out_overrun !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_sticky: got overrun %b valid %b, required 1 0", out_overrun, out_valid);
        end
        $display("[TB] backpressure overrun");
    endtask

    task automatic test_back_to_back();
        int c, rd;
        bit s;
        out_ready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            avg_log2 = 4'(pass);
            @(posedge mclk); #1;
            for (int i = 0; i < 8; i++) begin
                c = $urandom_range(950, 1050); s = 1'($urandom_range(0, 1)); rd = $urandom_range(0, 40000);
                model_push(c, 1999, s, rd);
                res_valid = 1'b1;
                res_data  = word(c, 1999, s, rd);
                @(posedge mclk); #1;
            end
            res_valid = 1'b0;
            wait_drain(20);
        end
        $display("[TB] back-to-back strobes");
    endtask

    task automatic test_reset_mid();
        int x0;
        avg_log2 = 4'd2;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(1000, 1999, 0, 10 * i + 5);
        send(1000, 1999, 0, 1);
        send(1000, 1999, 0, 2);
        send(1000, 1999, 0, 3);
        rst = 1'b1;
        @(posedge mclk); #1;
        n_tests++;
        if ({out_valid, out_data, out_range_err, out_overrun} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got %b/%h/%b/%b, required 0/00000000/0/0",
                     out_valid, out_data, out_range_err, out_overrun);
        end
        rst = 1'b0;
        exp_q.delete();
        model_reset();
        out_ready = 1'b1;
        x0 = n_xfer;
        for (int i = 0; i < 3; i++) send(1000, 1999, 1, 100 + i);
        repeat (6) @(posedge mclk);
        n_tests++;
        if (n_xfer !== x0) begin
            n_fail++;
            $display("FAIL reset_fresh_block: got %0d means after 3 samples, required 0", n_xfer - x0);
        end
        send(1000, 1999, 0, 900);
        wait_drain(20);
        n_tests++;
        if (n_xfer - x0 !== 1) begin
            n_fail++;
            $display("FAIL reset_block_count: got %0d means, required 1", n_xfer - x0);
        end
        $display("[TB] reset mid-block");
    endtask

    initial begin
        test_reset();
        test_scalar();
        test_average();
        test_floor_and_clamp();
        test_range();
        test_acc_clr();
        test_coincide();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_ms_result_avg.md
# adc_ms_result_avg

Post-processing stage directly downstream of the multislope ADC controller. It takes each 48-bit conversion result word, converts it to one signed charge-balance value in mclk units, and averages blocks of 2^avg_log2 conversions. The mean goes out through a valid/ready register to the UART frame builder. It also flags out-of-range samples and results that were lost because the consumer was not ready.

## Interface
Parameters:
- RUNUP_WEIGHT, default 3200: net charge of one run-up period in mclk cycles (80 slow ticks × 40 mclk); unsigned, < 2^14.

Ports:
- mclk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- res_valid  in  1  one-cycle strobe; res_data valid this cycle; no ready (source cannot stall).
- res_data  in  48  [47] ignored, [46:32] runup_cnt, [31] rundown_sign, [30:16] runup_set, [15:0] rundown_cnt; all unsigned except sign bit.
- avg_log2  in  4  block size exponent; values > 8 treated as 8; sampled on the first sample of each block.
- acc_clr  in  1  one-cycle strobe; abort current block.
- out_valid  out  1  out_data holds an unconsumed mean.
- out_ready  in  1  consumer accepts when out_valid && out_ready at a rising edge.
- out_data  out  32  signed block mean (two's complement).
- out_range_err  out  1  at least one sample in the block that produced out_data was out of range.
- out_overrun  out  1  sticky; a mean was overwritten before it was accepted.

## Operation
- Per-sample value: V = RUNUP_WEIGHT × (2·runup_cnt − runup_set − 1) + (rundown_sign ? −rundown_cnt : +rundown_cnt).
  - Run-up term: 17-bit signed.
  - Product and sum: 32-bit signed; no overflow is possible for legal inputs.
- Range error for a sample when runup_cnt > runup_set, or rundown_cnt == 16'hFFFF. The sample is still accumulated; the error is ORed into the block's error flag.
- Pipeline, 3 stages, no stall:
  - S1 registers the run-up term, the signed rundown and the error bit.
  - S2 registers V.
  - S3 updates the accumulator.
- Accumulator: 40-bit signed. sample_cnt is 9 bits. N = 2^min(avg_log2, 8) is latched when S3 sees the first sample of a block.
- Block control FSM:
  - ACC: each S3 sample does acc += V and sample_cnt++.
  - When a sample makes sample_cnt == N:
    - out_data <= (acc + V) >>> log2(N), floor rounding.
    - out_range_err <= block error flag.
    - out_valid <= 1.
    - acc, sample_cnt and the error flag reset to 0; the state stays ACC.
  - The FSM has only one state plus in-flight pipeline. The block boundary is purely count-driven.
- Output register:
  - Transfer when out_valid && out_ready: out_valid <= 0, unless a new mean is loaded in the same cycle.
  - New mean loaded while out_valid = 1 and no transfer that cycle: overwrite out_data, set out_overrun.
  - New mean loaded in the same cycle as a transfer: load the new mean, out_valid stays 1, no overrun.
- acc_clr:
  - Zeroes acc, sample_cnt and the error flag, and invalidates S1/S2 contents.
  - A res_valid in the same cycle is discarded.
  - The output register and out_overrun are unaffected.
- out_overrun clears only on rst.
- avg_log2 changes mid-block take effect at the next block start.

## Timing
- Reset values: out_valid 0, out_data 0, out_range_err 0, out_overrun 0, acc 0, sample_cnt 0, pipeline valids 0.
- Latency with res_valid high in cycle T:
  - S1 at edge T+1, S2 at T+2, S3/output load at T+3.
  - With N = 1, out_valid is first high in cycle T+3.
- Throughput: one sample per cycle; real results arrive every ≥ 10^5 mclk.
- rst mid-block: everything returns to reset values at the next edge; in-flight samples are lost.
- out_data and out_range_err are stable while out_valid = 1, unless overwritten by a new mean.

## Test plan
- Scalar value, avg_log2=0, RUNUP_WEIGHT=3200:
  - runup_cnt=1000, set=1999, sign=0, rundown=500 -> out_data=500 three cycles after the strobe.
  - Then runup_cnt=1100, sign=1, rundown=300 -> out_data=639700.
- Averaging, avg_log2=2: four samples with run-up term 0 and signed rundowns +100, +200, +300, −200 -> exactly one out_valid, out_data=100.
- Floor rounding, avg_log2=1: samples −2 and −3 -> out_data=−3. avg_log2=12 behaves as 8: one output per 256 samples.
- Range error and clear:
  - avg_log2=1, first sample has runup_cnt=2000 > set=1999 -> out_range_err=1 with that mean.
  - Next clean block -> out_range_err=0.
  - acc_clr pulsed with a res_valid in the same cycle, avg_log2=1 -> that sample is dropped; two more samples are needed for an output.
- Backpressure:
  - out_ready held 0 across two means -> out_data is the second mean, out_overrun=1 and stays 1 after acceptance.
  - Transfer coinciding with a new load -> out_valid stays 1, no overrun.
- Reset: rst asserted mid-block and with out_valid=1 -> all outputs 0 next cycle; the next block needs the full N fresh samples.
